// File: rtl/sat_addsub_arb.sv
// Round-robin arbiter in front of one shared 16-bit saturating add/subtract unit.
// One operation in flight; the tagged result is held until the consumer takes it.
module sat_addsub_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_sum,
    output logic                   rsp_pos_ovfl,
    output logic                   rsp_neg_ovfl,
    output logic [15:0]            sat_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_reg, state_next;
    logic [ID_W-1:0]       last_grant_reg;
    logic [15:0]           op_a_reg, op_b_reg;
    logic                  op_sub_reg;
    logic [ID_W-1:0]       op_id_reg;
    logic                  rsp_valid_reg;
    logic [ID_W-1:0]       rsp_id_reg;
    logic [15:0]           rsp_sum_reg;
    logic                  rsp_pos_reg, rsp_neg_reg;
    logic [15:0]           sat_cnt_reg;

    logic [15:0]           a_arr [NUM_REQ];
    logic [15:0]           b_arr [NUM_REQ];
    logic [ID_W-1:0]       cand_idx [NUM_REQ];
    logic                  arb_en, grant_found, grant_fire;
    logic [ID_W-1:0]       grant_idx;
    logic signed [16:0]    ext_a, ext_b, exact;
    logic                  pos_ovfl, neg_ovfl;
    logic [15:0]           sat_sum;

    // cand_idx[k] is the k-th candidate in round-robin order after the last winner.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi]    = req_a[16*gi +: 16];
        assign b_arr[gi]    = req_b[16*gi +: 16];
        assign cand_idx[gi] = ID_W'((int'(last_grant_reg) + gi + 1) % NUM_REQ);
    end

    assign arb_en = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        // Walk from the farthest candidate down so the nearest valid one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign grant_fire = arb_en && grant_found && !rst;
    assign req_ready  = grant_fire ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = grant_found ? EXEC : IDLE;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = grant_found ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Exact 17-bit result; subtracting 0x8000 must yield +32768, not a wrapped negate.
    assign ext_a    = {op_a_reg[15], op_a_reg};
    assign ext_b    = {op_b_reg[15], op_b_reg};
    assign exact    = op_sub_reg ? (ext_a - ext_b) : (ext_a + ext_b);
    assign pos_ovfl = !exact[16] && exact[15];
    assign neg_ovfl = exact[16] && !exact[15];
    assign sat_sum  = pos_ovfl ? 16'h7FFF : (neg_ovfl ? 16'h8000 : exact[15:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            op_sub_reg     <= 1'b0;
            op_id_reg      <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_sum_reg    <= '0;
            rsp_pos_reg    <= 1'b0;
            rsp_neg_reg    <= 1'b0;
            sat_cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_fire) begin
                op_a_reg       <= a_arr[grant_idx];
                op_b_reg       <= b_arr[grant_idx];
                op_sub_reg     <= req_sub[grant_idx];
                op_id_reg      <= grant_idx;
                last_grant_reg <= grant_idx;
            end
            if (state_reg == EXEC) begin
                rsp_valid_reg <= 1'b1;
                rsp_sum_reg   <= sat_sum;
                rsp_pos_reg   <= pos_ovfl;
                rsp_neg_reg   <= neg_ovfl;
                rsp_id_reg    <= op_id_reg;
            end else if ((state_reg == RESP) && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
                if ((rsp_pos_reg || rsp_neg_reg) && (sat_cnt_reg != 16'hFFFF))
                    sat_cnt_reg <= sat_cnt_reg + 16'd1;
            end
        end
    end

    assign rsp_valid    = rsp_valid_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_sum      = rsp_sum_reg;
    assign rsp_pos_ovfl = rsp_pos_reg;
    assign rsp_neg_ovfl = rsp_neg_reg;
    assign sat_cnt      = sat_cnt_reg;

endmodule
